sum_display_scanner: RTL and testbench
======================================

SUM_DISPLAY_SCANNER -- requirements
Module: sum_display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, is the number of clk cycles each digit is displayed; legal range 2..2^20.
REQ-002 Port clk  input  1  system clock; every register updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port load  input  1  snapshot strobe; when high, the operand and result inputs are captured.
REQ-005 Port A  input  4  adder operand A.
REQ-006 Port B  input  4  adder operand B.
REQ-007 Port Cin  input  1  adder carry-in.
REQ-008 Port Sum  input  4  adder sum result.
REQ-009 Port Couts  input  1  adder carry-out.
REQ-010 Port an  output  4  digit anodes, active-low, registered.
REQ-011 Port seg  output  7  segments, active-low, registered; seg[0]=a through seg[6]=g.
REQ-012 Port dp  output  1  decimal point, active-low, registered.

Function
REQ-013 When load=1 at a clk edge, the block SHALL capture A, B, Cin, Sum and Couts into the snapshot registers; when load=0, the snapshot SHALL hold its value.
REQ-014 Prescaler: cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick SHALL equal (cnt==REFRESH_DIV-1).
REQ-015 On tick, the 2-bit digit select sel SHALL advance 0->1->2->3->0, and the blank flag SHALL be set to 1 for exactly the next cycle.
REQ-016 Digit map: sel=0 shows Sum in hex; sel=1 shows Cin as 0/1; sel=2 shows B in hex; sel=3 shows A in hex. All values come from the snapshot.
REQ-017 an SHALL be 4'b1111 while blank=1; otherwise it SHALL be low only on bit[sel].
REQ-018 seg SHALL be the active-low hex decode of the selected snapshot nibble. Required codes: 0=1000000, 1=1111001, 8=0000000, 9=0010000, A=0001000, F=0001110; the remaining codes follow the standard 7-segment glyphs.
REQ-019 dp SHALL be 0 only when sel=0, blank=0 and the snapshot Couts=1; otherwise dp SHALL be 1.
REQ-020 Latency: an, seg and dp SHALL reflect a new sel or new snapshot value on the clk edge after that value changes (one registered stage).
REQ-021 If load and tick occur in the same cycle, both SHALL take effect; the following displayed digit SHALL use the new snapshot.
REQ-022 Each digit dwell SHALL be REFRESH_DIV cycles: 1 blank cycle followed by REFRESH_DIV-1 lit cycles. The full scan period SHALL be 4*REFRESH_DIV cycles.
REQ-023 An edge on load SHALL NOT reset or disturb cnt or sel.

Reset
REQ-024 While rst_n=0 at a clk edge, the following SHALL be cleared to 0: cnt, sel, blank, and the whole snapshot.
REQ-025 During reset: an=4'b1111, seg=7'b1111111, dp=1.
REQ-026 On the first edge after rst_n returns to 1: an=4'b1110, seg=1000000 (digit 0 shows "0").
REQ-027 Asserting reset mid-scan SHALL abandon the current dwell immediately, with no partial-state carryover.

Structure
REQ-028 A shared package SHALL hold the segment code constants (SEG_0..SEG_F, SEG_BLANK=7'b1111111) and the REFRESH_DIV default.
REQ-029 The block SHALL contain one combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), instanced once on the muxed nibble.
REQ-030 The counter width SHALL be sized to hold REFRESH_DIV-1.

Verification (REFRESH_DIV=4)
REQ-031 Reset: hold rst_n=0 for 3 cycles -> an=1111, seg=1111111, dp=1; after release -> an=1110, seg=1000000.
REQ-032 Snapshot: load=1 for one cycle with A=9, B=8, Cin=0, Sum=1, Couts=1. Required response:
  - sel=0: seg=1111001, dp=0.
  - sel=1: seg=1000000.
  - sel=2: seg=0000000.
  - sel=3: seg=0010000, dp=1.
REQ-033 Hold: after the snapshot, change A to F with load=0 over two full scans -> digit 3 still shows 9.
REQ-034 Blanking: at every sel change, an=1111 for exactly 1 cycle, then a one-hot low for 3 cycles; the scan order of the low bit is 0,1,2,3,0.
REQ-035 Collision: load with A=A, Sum=F in the same cycle as the tick to sel=3 -> the lit cycles of sel=3 show 0001000, and the next sel=0 shows 0001110.
REQ-036 Mid-scan reset: assert rst_n=0 while sel=2 and cnt=2 -> outputs match REQ-025 on the next edge; the snapshot reads 0 after release.

Source files
------------

// File: rtl/sum_display_scanner_pkg.sv
// ============================================================================
// Module   : sum_display_scanner_pkg
// Brief    : Shared segment codes, snapshot type and digit selection encoding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_display_scanner_pkg;

    localparam int REFRESH_DIV_DEFAULT = 100000;

    // Active-low segment codes, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       couts;
    } snapshot_t;

    typedef enum logic [1:0] {
        DIG_SUM = 2'd0,
        DIG_CIN = 2'd1,
        DIG_B   = 2'd2,
        DIG_A   = 2'd3
    } digit_sel_e;

    function automatic logic [3:0] anode_for(input logic [1:0] sel);
        anode_for = ~(4'b0001 << sel);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ============================================================================
// Module   : hex_to_seg7
// Brief    : Combinational hex nibble to active-low 7-segment decoder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
    import sum_display_scanner_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sum_display_scanner.sv
// ============================================================================
// Module   : sum_display_scanner
// Brief    : Snapshots a 4-bit adder's operands/result and scans them onto a
//            4-digit multiplexed 7-segment display with inter-digit blanking
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_display_scanner
    import sum_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    input  logic [3:0] Sum,
    input  logic       Couts,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int                 c_CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    digit_sel_e         r_sel;
    logic               r_blank;
    snapshot_t          r_snap;
    logic               w_tick;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg;

    assign w_tick = (r_cnt == c_CNT_MAX);

    // Scan timing and snapshot share one clock; load never touches cnt/sel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sel   <= DIG_SUM;
            r_blank <= 1'b0;
            r_snap  <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
            r_blank <= w_tick;
            if (w_tick) begin
                r_sel <= digit_sel_e'(r_sel + 2'd1);
            end
            if (load) begin
                r_snap <= '{a: A, b: B, cin: Cin, sum: Sum, couts: Couts};
            end
        end
    end

    always_comb begin
        w_nibble = r_snap.sum;
        case (r_sel)
            DIG_SUM: w_nibble = r_snap.sum;
            DIG_CIN: w_nibble = {3'b000, r_snap.cin};
            DIG_B:   w_nibble = r_snap.b;
            DIG_A:   w_nibble = r_snap.a;
            default: w_nibble = r_snap.sum;
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    // Output stage: one register after sel/blank/snapshot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= r_blank ? AN_OFF : anode_for(r_sel);
            seg <= w_seg;
            dp  <= !((r_sel == DIG_SUM) && !r_blank && r_snap.couts);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sum_display_scanner.sv
// ============================================================================
// Module   : tb_sum_display_scanner
// Brief    : Randomized and directed bench against a cycle-count display model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_display_scanner;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n, load, Cin, Couts;
    logic [3:0] A, B, Sum;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;

    // Model: edges since reset release, plus the snapshot as seen before the next edge
    int         m_k;
    logic [3:0] m_a, m_b, m_sum;
    logic       m_cin, m_cout;

    always #5 clk = ~clk;

    sum_display_scanner #(.REFRESH_DIV(RD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Couts (Couts),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic int next_sel();
        return (m_k / RD) % 4;
    endfunction

    function automatic int next_cnt();
        return m_k % RD;
    endfunction

    function automatic bit next_blank();
        return (m_k % RD == 0) && (m_k > 0);
    endfunction

    task automatic cyc(input logic rn, input logic ld, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic c, input logic co);
        logic [3:0] exp_an, nib;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         d;
        bit         bl;
        @(negedge clk);
        rst_n = rn; load = ld; A = a; B = b; Sum = s; Cin = c; Couts = co;
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            m_k = 0;
            {m_a, m_b, m_sum, m_cin, m_cout} = '0;
        end else begin
            d  = next_sel();
            bl = next_blank();
            case (d)
                0: nib = m_sum;
                1: nib = {3'b000, m_cin};
                2: nib = m_b;
                default: nib = m_a;
            endcase
            exp_an  = bl ? 4'hF : (4'hF ^ (4'h1 << d));
            exp_seg = glyph(nib);
            exp_dp  = !(d == 0 && !bl && m_cout);
            if (ld) begin
                m_a = a; m_b = b; m_sum = s; m_cin = c; m_cout = co;
            end
            m_k++;
        end
        check("an", {28'd0, an}, {28'd0, exp_an});
        check("seg", {25'd0, seg}, {25'd0, exp_seg});
        check("dp", {31'd0, dp}, {31'd0, exp_dp});
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int  s;
        bit  b;
        int  guard;
        rst_n = 1'b0; load = 1'b0; A = '0; B = '0; Sum = '0; Cin = 1'b0; Couts = 1'b0;
        m_k = 0;
        {m_a, m_b, m_sum, m_cin, m_cout} = '0;

        // Reset hold and release
        repeat (3) cyc(1'b0, 1'b0, 4'h5, 4'h6, 4'h7, 1'b1, 1'b1);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        idle();
        check("rel_an", {28'd0, an}, 32'hE);
        check("rel_seg", {25'd0, seg}, 32'h40);

        // Snapshot then hold across two scans with A changed to F
        cyc(1'b1, 1'b1, 4'h9, 4'h8, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 2 * 4 * RD; i++) begin
            s = next_sel();
            b = next_blank();
            idle();
            if (!b) begin
                case (s)
                    0: begin
                        check("snap_d0_seg", {25'd0, seg}, 32'h79);
                        check("snap_d0_dp", {31'd0, dp}, 32'd0);
                    end
                    1: check("snap_d1_seg", {25'd0, seg}, 32'h40);
                    2: check("snap_d2_seg", {25'd0, seg}, 32'h00);
                    default: begin
                        check("hold_d3_seg", {25'd0, seg}, 32'h10);
                        check("hold_d3_dp", {31'd0, dp}, 32'd1);
                    end
                endcase
            end else begin
                check("blank_an", {28'd0, an}, 32'hF);
            end
        end

        // Load coinciding with the tick into sel=3
        guard = 0;
        while (!(next_cnt() == RD - 1 && next_sel() == 2) && guard < 40) begin
            idle();
            guard++;
        end
        cyc(1'b1, 1'b1, 4'hA, 4'h3, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 2 * RD; i++) begin
            s = next_sel();
            b = next_blank();
            idle();
            if (!b && s == 3) check("coll_d3_seg", {25'd0, seg}, 32'h08);
            if (!b && s == 0) check("coll_d0_seg", {25'd0, seg}, 32'h0E);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();

        // Reset in the middle of the sel=2 dwell
        cyc(1'b1, 1'b1, 4'h7, 4'hC, 4'hD, 1'b1, 1'b1);
        guard = 0;
        while (!(next_cnt() == 2 && next_sel() == 2) && guard < 40) begin
            idle();
            guard++;
        end
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("midrst_an", {28'd0, an}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'h7F);
        check("midrst_dp", {31'd0, dp}, 32'd1);
        idle();
        check("midrst_rel_an", {28'd0, an}, 32'hE);
        check("midrst_rel_seg", {25'd0, seg}, 32'h40);
        repeat (4 * RD) idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
